// File: rtl/reduce_stream_n.sv
// Frame reducer: folds every beat of a valid/ready frame with AND/OR/XOR and
// presents one registered result (word, reduced bit, beat count) per frame.
module reduce_stream_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_bit,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_out_word;
    logic               r_out_bit;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_busy;

    logic               w_accept;
    logic               w_first;
    logic [1:0]         w_op_eff;
    logic [WIDTH-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_count_next;

    // Reserved operator code 11 falls through to AND.
    function automatic logic [WIDTH-1:0] f_fold(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       o);
        case (o)
            OP_OR:   f_fold = a | b;
            OP_XOR:  f_fold = a ^ b;
            default: f_fold = a & b;
        endcase
    endfunction

    function automatic logic f_reduce(input logic [WIDTH-1:0] w,
                                      input logic [1:0]       o);
        case (o)
            OP_OR:   f_reduce = |w;
            OP_XOR:  f_reduce = ^w;
            default: f_reduce = &w;
        endcase
    endfunction

    assign in_ready  = (r_state != HOLD) || out_ready;
    assign w_accept  = in_valid && in_ready;
    // Any accepted beat outside ACCUM opens a new frame (IDLE, or HOLD being drained).
    assign w_first   = w_accept && (r_state != ACCUM);
    assign w_op_eff  = w_first ? op : r_op;

    assign w_acc_next   = w_first ? in_data : f_fold(r_acc, in_data, r_op);
    assign w_count_next = w_first ? CNT_W'(1)
                        : (&r_count) ? r_count
                        : r_count + CNT_W'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_next = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_next = in_last ? HOLD : ACCUM;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ACCUM);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_op        <= 2'b00;
            r_out_word  <= '0;
            r_out_bit   <= 1'b0;
            r_out_count <= '0;
        end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            if (w_first) begin
                r_op <= op;
            end
            if (in_last) begin
                r_out_word  <= w_acc_next;
                r_out_count <= w_count_next;
                r_out_bit   <= f_reduce(w_acc_next, w_op_eff);
            end
        end
    end

    assign out_word  = r_out_word;
    assign out_bit   = r_out_bit;
    assign out_count = r_out_count;
    assign out_valid = (r_state == HOLD);
    assign busy      = r_busy;

endmodule

// File: tb/tb_reduce_stream_n.sv
// Self-checking bench for reduce_stream_n: directed frames from the plan plus
// random traffic, compared against a frame-level reference model.
module tb_reduce_stream_n;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       op;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] out_word;
    logic             out_bit;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats of the open frame and the pending result.
    logic [WIDTH-1:0] m_beats[$];
    logic [1:0]       m_op;
    logic             m_open = 1'b0;
    logic             m_hold = 1'b0;
    logic [WIDTH-1:0] m_word;
    logic             m_bit;
    int               m_cnt;

    reduce_stream_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_bit   (out_bit),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic close_frame();
        logic [WIDTH-1:0] acc;
        acc = m_beats[0];
        for (int i = 1; i < m_beats.size(); i++) begin
            case (m_op)
                2'b01:   acc = acc | m_beats[i];
                2'b10:   acc = acc ^ m_beats[i];
                default: acc = acc & m_beats[i];
            endcase
        end
        m_word = acc;
        m_bit  = (m_op == 2'b01) ? |acc : (m_op == 2'b10) ? ^acc : &acc;
        m_cnt  = (m_beats.size() > CMAX) ? CMAX : m_beats.size();
    endtask

    // One cycle: drive at negedge, check, advance model across posedge.
    task automatic step(input logic v, input logic l, input logic [WIDTH-1:0] d,
                        input logic [1:0] o, input logic rdy);
        logic accepted;
        logic consumed;
        in_valid = v; in_last = l; in_data = d; op = o; out_ready = rdy;
        #1;
        check("in_ready", 32'(in_ready), m_hold ? 32'(rdy) : 32'd1);
        check("out_valid", 32'(out_valid), 32'(m_hold));
        check("busy", 32'(busy), 32'(m_open));
        if (m_hold) begin
            check("out_word", 32'(out_word), 32'(m_word));
            check("out_bit", 32'(out_bit), 32'(m_bit));
            check("out_count", 32'(out_count), 32'(m_cnt));
        end
        accepted = v && (!m_hold || rdy);
        consumed = m_hold && rdy;
        @(posedge clk);
        if (consumed) m_hold = 1'b0;
        if (accepted) begin
            if (!m_open) begin
                m_beats.delete();
                m_op = o;
            end
            m_beats.push_back(d);
            if (l) begin
                close_frame();
                m_hold = 1'b1;
                m_open = 1'b0;
            end else begin
                m_open = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_word"}, 32'(out_word), 32'd0);
        check({tag, "_bit"}, 32'(out_bit), 32'd0);
        check({tag, "_count"}, 32'(out_count), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Reset asserted away from any clock edge; a beat offered meanwhile must be dropped.
    task automatic mid_reset();
        #2;
        reset = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        #1;
        check_zero("rst_now");
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        m_open = 1'b0; m_hold = 1'b0; m_beats.delete();
    endtask

    initial begin
        reset = 1'b1; op = 2'b00; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // AND frame FF, F0, 3C
        step(1, 0, 8'hFF, 2'b00, 1);
        step(1, 0, 8'hF0, 2'b11, 1);
        check("t_and_busy", 32'(busy), 32'd1);
        step(1, 1, 8'h3C, 2'b00, 1);
        check("t_and_word", 32'(out_word), 32'h30);
        check("t_and_bit", 32'(out_bit), 32'd0);
        check("t_and_cnt", 32'(out_count), 32'd3);
        step(0, 0, 8'h00, 2'b00, 1);

        // OR then XOR frames
        step(1, 0, 8'h01, 2'b01, 1);
        step(1, 1, 8'h80, 2'b01, 1);
        check("t_or_word", 32'(out_word), 32'h81);
        check("t_or_bit", 32'(out_bit), 32'd1);
        step(1, 0, 8'h0F, 2'b10, 1);
        step(1, 1, 8'h0E, 2'b10, 0);
        check("t_xor_word", 32'(out_word), 32'h01);
        check("t_xor_bit", 32'(out_bit), 32'd1);

        // Backpressure: five stalled cycles with beats offered, then release
        for (int i = 0; i < 5; i++) step(1, 0, 8'hC3, 2'b01, 0);
        step(1, 0, 8'hA5, 2'b01, 1);
        step(1, 1, 8'h5A, 2'b00, 1);
        check("t_bp_word", 32'(out_word), 32'hFF);
        step(0, 0, 8'h00, 2'b00, 1);

        // op change mid-frame is ignored; count saturates
        step(1, 0, 8'hFF, 2'b00, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 8'hFF, 2'b01, 1);
        step(1, 1, 8'hFF, 2'b01, 1);
        check("t_sat_word", 32'(out_word), 32'hFF);
        check("t_sat_cnt", 32'(out_count), 32'd3);
        step(0, 0, 8'h00, 2'b00, 1);

        // Streaming single-beat frames
        step(1, 1, 8'h00, 2'b00, 1);
        check("t_s0_bit", 32'(out_bit), 32'd0);
        step(1, 1, 8'hFF, 2'b00, 1);
        check("t_s1_bit", 32'(out_bit), 32'd1);
        step(1, 1, 8'hAA, 2'b00, 1);
        check("t_s2_bit", 32'(out_bit), 32'd0);
        check("t_s2_cnt", 32'(out_count), 32'd1);
        step(0, 0, 8'h00, 2'b00, 1);

        // Reset between beats 2 and 3, then a fresh frame
        step(1, 0, 8'h0F, 2'b01, 1);
        step(1, 0, 8'hF0, 2'b01, 1);
        mid_reset();
        step(0, 0, 8'h00, 2'b00, 1);
        step(1, 0, 8'h12, 2'b01, 1);
        step(1, 1, 8'h21, 2'b01, 0);
        check("t_rst_word", 32'(out_word), 32'h33);
        check("t_rst_cnt", 32'(out_count), 32'd2);
        step(0, 0, 8'h00, 2'b00, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 3) == 0),
                 WIDTH'($urandom),
                 2'($urandom),
                 logic'($urandom_range(0, 3) != 0));
        end
        step(0, 0, 8'h00, 2'b00, 1);
        step(0, 0, 8'h00, 2'b00, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
